hex_seq_display: RTL and testbench



---
 rtl/hex_seq_display_if.sv | 14 +
 rtl/hex_seq_display.sv | 131 +++++++++++++
 tb/tb_hex_seq_display.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/hex_seq_display_if.sv
// Board-side I/O bundle for hex_seq_display: switches, keys and mode select in,
// seven-segment digits and LEDs out.
interface hex_seq_display_if #(
    parameter int unsigned N_DIGITS = 6
);
    logic [9:0]            SW;
    logic [3:0]            KEY;
    logic [1:0]            MODE;
    logic [7*N_DIGITS-1:0] HEX;
    logic [9:0]            LED;

    modport master (output SW, KEY, MODE, input HEX, LED);
    modport slave  (input SW, KEY, MODE, output HEX, LED);
endinterface

// File: rtl/hex_seq_display.sv
// Seven-segment sequencer: rotating snake, hex counter, static switch value or blank.
// Define HEX_SEQ_LZ_BLANK_EN to blank leading zero digits in hex-counter mode.
module hex_seq_display #(
    parameter int unsigned N_DIGITS   = 6,
    parameter int unsigned PRESCALE   = 25000000,
    parameter logic [6:0]  SNAKE_INIT = 7'd1
) (
    input logic              CLK,
    input logic              RST_N,
    hex_seq_display_if.slave io
);
    localparam int unsigned    CW      = 4 * N_DIGITS;
    localparam int unsigned    PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]  PS_LAST = PW'(PRESCALE - 1);

    logic [3:0]            key_s1, key_s2, key_prev, key_fall;
    logic                  run, dir;
    logic [6:0]            p;
    logic [CW-1:0]         cnt;
    logic [PW-1:0]         pcnt;
    logic                  tick, do_clear, do_load;
    logic [11:0]           sw12;
    logic [7*N_DIGITS-1:0] hex_nxt;

    function automatic logic [6:0] hex7seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Rotate left by k (0..6): the upper half of the doubled pattern after shifting.
    function automatic logic [6:0] rotl7(input logic [6:0] v, input int unsigned k);
        logic [13:0] d;
        d = {v, v} << k;
        return d[13:7];
    endfunction

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            key_s1   <= '1;
            key_s2   <= '1;
            key_prev <= '1;
        end else begin
            key_s1   <= io.KEY;
            key_s2   <= key_s1;
            key_prev <= key_s2;
        end
    end

    assign key_fall = key_prev & ~key_s2;
    assign do_clear = key_fall[2];
    assign do_load  = key_fall[3];
    assign tick     = run && (pcnt == PS_LAST);
    assign sw12     = {2'b00, io.SW};

    // Clear overrides everything on CNT/P/prescaler; load overrides only the CNT step.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            run  <= 1'b1;
            dir  <= 1'b0;
            p    <= SNAKE_INIT;
            cnt  <= '0;
            pcnt <= '0;
        end else begin
            run <= run ^ key_fall[0];
            dir <= dir ^ key_fall[1];
            if (do_clear) begin
                pcnt <= '0;
                p    <= SNAKE_INIT;
                cnt  <= '0;
            end else begin
                if (run)
                    pcnt <= tick ? '0 : pcnt + 1'b1;
                if (tick)
                    p <= dir ? {p[0], p[6:1]} : {p[5:0], p[6]};
                if (do_load)
                    cnt <= CW'(io.SW);
                else if (tick)
                    cnt <= dir ? cnt - 1'b1 : cnt + 1'b1;
            end
        end
    end

    always_comb begin
        hex_nxt = '0;
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
            case (io.MODE)
                2'd0: hex_nxt[7*i +: 7] = rotl7(p, i % 7);
                2'd1: hex_nxt[7*i +: 7] = hex7seg(cnt[4*i +: 4]);
                2'd2: if (i < 3) hex_nxt[7*i +: 7] = hex7seg(sw12[4*i +: 4]);
                default: hex_nxt[7*i +: 7] = '0;
            endcase
        end
`ifdef HEX_SEQ_LZ_BLANK_EN
        if (io.MODE == 2'd1) begin
            for (int unsigned i = 1; i < N_DIGITS; i++) begin
                if ((cnt >> (4*i)) == '0)
                    hex_nxt[7*i +: 7] = '0;
            end
        end
`else
`endif
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            io.HEX <= '0;
            io.LED <= '0;
        end else begin
            io.HEX <= hex_nxt;
            io.LED <= {8'(cnt), dir, run};
        end
    end
endmodule

// File: tb/tb_hex_seq_display.sv
// Scoreboard bench for hex_seq_display: a cycle-level reference model pushes expected
// HEX/LED per edge, a negedge monitor pops and compares.
module tb_hex_seq_display;
    localparam int unsigned     ND    = 6;
    localparam int unsigned     PS    = 4;
    localparam logic [6:0]      INIT  = 7'd1;
    localparam int unsigned     CW    = 4 * ND;
    localparam longint unsigned CMASK = (64'd1 << CW) - 1;
`ifdef HEX_SEQ_LZ_BLANK_EN
    localparam logic [6:0]      HI_ZERO = 7'h00;
`else
    localparam logic [6:0]      HI_ZERO = 7'h3F;
`endif

    typedef struct packed {
        logic [7*ND-1:0] hex;
        logic [9:0]      led;
    } exp_t;

    logic CLK = 1'b0;
    logic RST_N;
    always #5 CLK = ~CLK;

    hex_seq_display_if #(.N_DIGITS(ND)) bus  ();
    hex_seq_display_if #(.N_DIGITS(ND)) bus1 ();

    hex_seq_display #(.N_DIGITS(ND), .PRESCALE(PS), .SNAKE_INIT(INIT)) dut (
        .CLK(CLK), .RST_N(RST_N), .io(bus));
    hex_seq_display #(.N_DIGITS(ND), .PRESCALE(1), .SNAKE_INIT(INIT)) dut1 (
        .CLK(CLK), .RST_N(RST_N), .io(bus1));

    logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    int n_tests = 0;
    int n_fail  = 0;
    exp_t sb[$];

    // Reference state
    int              m_run, m_dir, m_p, m_pcnt;
    longint unsigned m_cnt;
    logic [3:0]      key_hist[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7*ND-1:0] exp_hex(input int mode, input logic [9:0] sw,
                                               input longint unsigned cnt, input int p);
        logic [7*ND-1:0] h;
        int k, d;
        h = '0;
        for (int i = 0; i < ND; i++) begin
            k = i % 7;
            d = 0;
            case (mode)
                0: d = ((p << k) | (p >> (7 - k))) & 'h7F;
                1: d = int'(glyph[int'((cnt >> (4*i)) & 15)]);
                2: if (i < 3) d = int'(glyph[(int'(sw) >> (4*i)) & 15]);
                default: d = 0;
            endcase
`ifdef HEX_SEQ_LZ_BLANK_EN
            if (mode == 1 && i > 0 && (cnt >> (4*i)) == 0) d = 0;
`endif
            h[7*i +: 7] = d[6:0];
        end
        return h;
    endfunction

    task automatic model_reset();
        m_run = 1; m_dir = 0; m_p = int'(INIT); m_pcnt = 0; m_cnt = 0;
        key_hist.delete();
        repeat (3) key_hist.push_back(4'hF);
    endtask

    // One rising edge: outputs reflect the state held before the edge; a key press
    // acts on the edge after it has passed through two sampling stages.
    task automatic model_edge();
        exp_t e;
        logic [3:0] fall;
        int tick;
        e.hex = exp_hex(int'(bus.MODE), bus.SW, m_cnt, m_p);
        e.led = {8'(m_cnt & 255), 1'(m_dir), 1'(m_run)};
        sb.push_back(e);

        fall = key_hist[0] & ~key_hist[1];
        void'(key_hist.pop_front());
        key_hist.push_back(bus.KEY);

        tick = (m_run == 1 && m_pcnt == PS - 1) ? 1 : 0;
        if (fall[2]) begin
            m_pcnt = 0; m_cnt = 0; m_p = int'(INIT);
        end else begin
            if (m_run == 1) m_pcnt = (m_pcnt + 1) % PS;
            if (tick == 1) begin
                if (m_dir == 1) m_p = ((m_p >> 1) | ((m_p & 1) << 6)) & 'h7F;
                else            m_p = ((m_p << 1) | (m_p >> 6)) & 'h7F;
            end
            if (fall[3])        m_cnt = longint'(bus.SW);
            else if (tick == 1) m_cnt = (m_dir == 1) ? (m_cnt + CMASK) & CMASK
                                                     : (m_cnt + 1) & CMASK;
        end
        if (fall[0]) m_run = 1 - m_run;
        if (fall[1]) m_dir = 1 - m_dir;
    endtask

    always @(negedge CLK) begin
        if (RST_N && sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("sb_hex", 64'(bus.HEX), 64'(e.hex));
            check("sb_led", 64'(bus.LED), 64'(e.led));
        end
    end

    task automatic tick_clk();
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
    endtask

    task automatic do_reset();
        #1 RST_N = 1'b0;
        #2;
        sb.delete();
        model_reset();
        check("rst_hex", 64'(bus.HEX), 64'd0);
        check("rst_led", 64'(bus.LED), 64'd0);
        @(negedge CLK);
        #1 RST_N = 1'b1;
    endtask

    logic [3:0] kv;

    initial begin
        bus.SW = '0; bus.KEY = '1; bus.MODE = 2'd0;
        bus1.SW = '0; bus1.KEY = '1; bus1.MODE = 2'd0;
        RST_N = 1'b0;
        model_reset();
        #2;
        check("por_hex", 64'(bus.HEX), 64'd0);
        check("por_led", 64'(bus.LED), 64'd0);
        @(negedge CLK);
        #1 RST_N = 1'b1;

        // Snake start-up; the PRESCALE=1 instance counts every edge
        for (int k = 1; k <= 6; k++) begin
            tick_clk();
            check("ps1_cnt", 64'(bus1.LED[9:2]), 64'(k - 1));
            if (k == 2) begin
                check("snk_hex0", 64'(bus.HEX[6:0]), 64'h01);
                check("snk_hex1", 64'(bus.HEX[13:7]), 64'h02);
                check("snk_hex5", 64'(bus.HEX[41:35]), 64'h20);
                check("snk_led", 64'(bus.LED), 64'h001);
            end
        end
        check("snk_hex0_b", 64'(bus.HEX[6:0]), 64'h02);
        check("snk_hex5_b", 64'(bus.HEX[41:35]), 64'h40);

        // 17 ticks in hex-counter mode
        do_reset();
        bus.MODE = 2'd1;
        repeat (69) tick_clk();
        check("cnt_hex0", 64'(bus.HEX[6:0]), 64'h06);
        check("cnt_hex1", 64'(bus.HEX[13:7]), 64'h06);
        check("cnt_hex2", 64'(bus.HEX[20:14]), 64'(HI_ZERO));
        check("cnt_hex5", 64'(bus.HEX[41:35]), 64'(HI_ZERO));
        check("cnt_led", 64'(bus.LED[9:2]), 64'h11);

        // Direction flip before first tick: counter wraps down to all ones
        do_reset();
        bus.MODE = 2'd1;
        bus.KEY = 4'hD;
        repeat (5) tick_clk();
        bus.KEY = 4'hF;
        check("wrap_hex", 64'(bus.HEX), 64'({ND{7'h71}}));
        check("wrap_dir", 64'(bus.LED[1]), 64'd1);

        // Clear and load together, then load alone, shown in static mode
        bus.SW = 10'h2A5;
        bus.KEY = 4'h3;
        repeat (3) tick_clk();
        bus.KEY = 4'hF;
        repeat (3) tick_clk();
        bus.KEY = 4'h7;
        repeat (3) tick_clk();
        bus.KEY = 4'hF;
        bus.MODE = 2'd2;
        repeat (3) tick_clk();
        check("sw_hex0", 64'(bus.HEX[6:0]), 64'h6D);
        check("sw_hex2", 64'(bus.HEX[20:14]), 64'h5B);
        check("sw_hi", 64'(bus.HEX[41:21]), 64'd0);

        // Randomised run with a mid-count asynchronous reset
        kv = 4'hF;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 15) == 0) bus.MODE = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 31) == 0) bus.SW = 10'($urandom);
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 39) == 0) kv[b] = ~kv[b];
            bus.KEY = kv;
            if (c == 1500) begin
                @(posedge CLK);
                model_edge();
                #3 RST_N = 1'b0;
                #1;
                check("arst_hex", 64'(bus.HEX), 64'd0);
                check("arst_led", 64'(bus.LED), 64'd0);
                check("arst_ps1", 64'(bus1.LED), 64'd0);
                sb.delete();
                model_reset();
                kv = 4'hF;
                bus.KEY = kv;
                @(negedge CLK);
                #1 RST_N = 1'b1;
            end else begin
                tick_clk();
            end
        end
        #2;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
